rr_reg_arbiter: RTL and testbench
=================================

Name: rr_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer that shares one WIDTH-bit storage register (a bank of D flip-flops) between NREQ requesters.
- Each cycle it grants at most one requester. The granted requester's data is captured at the next rising clk edge.
- Supports locked multi-cycle ownership and a synchronous clear.
- Sits between requesting control blocks and the shared state register.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the shared register in bits.
- IDW, $clog2(NREQ), width of the owner index (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of stored data and ownership.
- req  input  NREQ  per-requester write request.
- lock  input  NREQ  per-requester request to keep ownership after the grant.
- wdata  input  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, combinational from current state and req.
- q  output  WIDTH  shared register contents.
- q_owner  output  IDW  index of the requester that last wrote q.
- q_valid  output  1  q holds data written since reset/clr.
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset (rst=0, asynchronous):
  - q=0, q_owner=0, q_valid=0, ptr=0, state=IDLE, busy=0.
  - gnt forced to 0 while rst=0.
- ptr is the highest-priority index. Search order: ptr, ptr+1, ... wrapping mod NREQ.
- IDLE:
  - gnt = one-hot of the first i in search order with req[i]=1; gnt=0 if no req.
  - On the edge with gnt[i]=1: q<=wdata[i], q_owner<=i, q_valid<=1, ptr<=(i+1) mod NREQ.
  - If lock[i]=1 on that edge, go to LOCKED with lock_id=i. Otherwise stay IDLE.
- LOCKED (owner lock_id):
  - All other requesters see gnt=0 regardless of req.
  - req[lock_id]=1 and lock[lock_id]=1: gnt[lock_id]=1, write on the edge, stay LOCKED.
  - req[lock_id]=1 and lock[lock_id]=0: gnt[lock_id]=1, write (final beat), go to IDLE.
  - req[lock_id]=0: gnt=0, no write, go to IDLE. This costs one dead cycle.
  - ptr stays at lock_id+1 throughout.
- Write latency:
  - gnt is asserted in the same cycle as req.
  - q reflects the data one rising edge later.
- clr=1 (synchronous, highest priority after rst):
  - gnt=0 in that cycle.
  - On the edge: q<=0, q_valid<=0, q_owner<=0, state<=IDLE.
  - ptr is unchanged.
  - A pending lock is abandoned.
- Simultaneous requests: exactly one grant per cycle; gnt is never multi-hot.
- Wrap-around: a grant to NREQ-1 sets ptr=0.
- Reset asserted mid-LOCKED returns to IDLE immediately. Outputs follow the reset values without waiting for clk.
- Changes in req/wdata between edges affect only the combinational gnt. Storage changes only at rising edges.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_LOCKED=1'b1;
  - the IDW derivation function (clog2).
- One natural sub-module: rr_reg_bank.
  - WIDTH-bit enabled flop bank with asynchronous active-low reset to 0.
  - Ports: clk, rst, en, clr, d, q.
  - Instantiated once for q. Arbiter state (ptr, state, lock_id, q_owner, q_valid) lives in rr_reg_arbiter.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 -> gnt=0, q=0, q_valid=0, q_owner=0. Release rst -> first grant goes to requester 0.
- Single write: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 same cycle; after one edge q=8'hA5, q_owner=2, q_valid=1.
- Rotation: req=4'b1111 held for 5 cycles, no lock -> gnt sequence 0001, 0010, 0100, 1000, 0001; q follows each requester's data.
- Lock: requester 1 with req=1 and lock=1 for 3 cycles while req=4'b1111 -> gnt=0010 for 3 cycles, busy=1. Then lock[1]=0 -> one final gnt=0010, and the next grant is requester 2.
- clr mid-lock: in LOCKED with owner 3, assert clr=1 for one cycle -> gnt=0 that cycle; after the edge q=0, q_valid=0, busy=0. The next grant follows ptr=0.
- Async reset mid-lock: drop rst between edges while busy=1 -> busy, q, q_valid go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/rr_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter.
// FSM encoding and owner-index width helper.
package rr_reg_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic int idw_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_reg_bank.sv
// Enabled D flop bank holding the shared register.
// Clear wins over enable; async active-low reset to zero.
module rr_reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one register among NREQ writers.
// Supports locked multi-beat ownership and synchronous clear.
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = idw_f(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        q_owner,
  output logic                  q_valid,
  output logic                  busy
);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] nxt_ptr;
  logic           found;
  logic           wen;

  // first requester at or after ptr, wrapping
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        cand  = IDW'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (rst && !clr) begin
      if (state == ST_LOCKED) begin
        gnt[lock_id] = req[lock_id];
      end else if (found) begin
        gnt[cand] = 1'b1;
      end
    end
  end

  assign win_id  = (state == ST_LOCKED) ? lock_id : cand;
  assign wen     = |gnt;
  assign nxt_ptr = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
  assign busy    = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      lock_id <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      state   <= ST_IDLE;
      q_owner <= '0;
      q_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (wen) begin
            q_owner <= win_id;
            q_valid <= 1'b1;
            ptr     <= nxt_ptr;
            if (lock[win_id]) begin
              state   <= ST_LOCKED;
              lock_id <= win_id;
            end
          end
        end
        ST_LOCKED: begin
          // dropping req costs a dead cycle back to IDLE
          if (wen) begin
            q_owner <= win_id;
            q_valid <= 1'b1;
            if (!lock[lock_id]) state <= ST_IDLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rr_reg_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .en (wen),
    .clr(clr),
    .d  (wdata[win_id*WIDTH +: WIDTH]),
    .q  (q)
  );

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter.
// Directed steps push expectations; a negedge monitor checks them.
module tb_rr_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  typedef struct {
    int              id;
    logic [NREQ-1:0] gnt;
    logic [7:0]      q;
    logic [IDW-1:0]  own;
    logic            vld;
    logic            busy;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [IDW-1:0]        q_owner;
  logic                  q_valid;
  logic                  busy;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   step_no;

  localparam logic [31:0] W0 = {8'h44, 8'hA5, 8'h22, 8'h11};

  rr_reg_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .req    (req),
    .lock   (lock),
    .wdata  (wdata),
    .gnt    (gnt),
    .q      (q),
    .q_owner(q_owner),
    .q_valid(q_valid),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || q !== e.q || q_owner !== e.own ||
          q_valid !== e.vld || busy !== e.busy) begin
        n_bad++;
        $display("FAIL step%0d: got gnt=%b q=%h own=%0d vld=%b busy=%b, want gnt=%b q=%h own=%0d vld=%b busy=%b",
                 e.id, gnt, q, q_owner, q_valid, busy,
                 e.gnt, e.q, e.own, e.vld, e.busy);
      end
    end
  end

  task automatic step(
    input logic            r,
    input logic            c,
    input logic [NREQ-1:0] rq,
    input logic [NREQ-1:0] lk,
    input logic [31:0]     wd,
    input logic [NREQ-1:0] eg,
    input logic [7:0]      eq,
    input logic [IDW-1:0]  eo,
    input logic            ev,
    input logic            eb
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst   = r;
    clr   = c;
    req   = rq;
    lock  = lk;
    wdata = wd;
    step_no++;
    e.id   = step_no;
    e.gnt  = eg;
    e.q    = eq;
    e.own  = eo;
    e.vld  = ev;
    e.busy = eb;
    sb.push_back(e);
  endtask

  initial begin
    int guard;
    n_cmp   = 0;
    n_bad   = 0;
    step_no = 0;
    rst   = 1'b0;
    clr   = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = W0;
    // reset holds grants off
    step(0, 0, 4'b1111, 4'b0000, W0, 4'b0000, 8'h00, 0, 0, 0);
    step(0, 0, 4'b1111, 4'b0000, W0, 4'b0000, 8'h00, 0, 0, 0);
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b0001, 8'h00, 0, 0, 0);
    // single write from requester 2
    step(1, 0, 4'b0100, 4'b0000, W0, 4'b0100, 8'h11, 0, 1, 0);
    step(1, 0, 4'b0000, 4'b0000, W0, 4'b0000, 8'hA5, 2, 1, 0);
    // requester 3 wraps ptr to 0
    step(1, 0, 4'b1000, 4'b0000, W0, 4'b1000, 8'hA5, 2, 1, 0);
    // rotation
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b0001, 8'h44, 3, 1, 0);
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b0010, 8'h11, 0, 1, 0);
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b0100, 8'h22, 1, 1, 0);
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b1000, 8'hA5, 2, 1, 0);
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b0001, 8'h44, 3, 1, 0);
    // locked burst by requester 1
    step(1, 0, 4'b1111, 4'b0010, 32'h44A56111, 4'b0010, 8'h11, 0, 1, 0);
    step(1, 0, 4'b1111, 4'b0010, 32'h44A56211, 4'b0010, 8'h61, 1, 1, 1);
    step(1, 0, 4'b1111, 4'b0010, 32'h44A56311, 4'b0010, 8'h62, 1, 1, 1);
    step(1, 0, 4'b1111, 4'b0000, 32'h44A56411, 4'b0010, 8'h63, 1, 1, 1);
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b0100, 8'h64, 1, 1, 0);
    // clr abandons lock held by requester 3
    step(1, 0, 4'b1000, 4'b1000, W0, 4'b1000, 8'hA5, 2, 1, 0);
    step(1, 1, 4'b1111, 4'b1000, W0, 4'b0000, 8'h44, 3, 1, 1);
    step(1, 0, 4'b1111, 4'b0000, W0, 4'b0001, 8'h00, 0, 0, 0);
    // owner drops req: dead cycle then IDLE
    step(1, 0, 4'b0010, 4'b0010, W0, 4'b0010, 8'h11, 0, 1, 0);
    step(1, 0, 4'b1101, 4'b0000, W0, 4'b0000, 8'h22, 1, 1, 1);
    step(1, 0, 4'b1101, 4'b0000, W0, 4'b0100, 8'h22, 1, 1, 0);
    // async reset mid-lock
    step(1, 0, 4'b1000, 4'b1000, W0, 4'b1000, 8'hA5, 2, 1, 0);
    step(1, 0, 4'b1000, 4'b1000, W0, 4'b1000, 8'h44, 3, 1, 1);
    step(0, 0, 4'b1000, 4'b1000, W0, 4'b0000, 8'h00, 0, 0, 0);
    step(1, 0, 4'b0010, 4'b0000, W0, 4'b0010, 8'h00, 0, 0, 0);
    step(1, 0, 4'b0000, 4'b0000, W0, 4'b0000, 8'h22, 1, 1, 0);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
